// File: rtl/pe_accumulator.sv
// Dot-product accumulator behind the PE compute unit: sums Len terms from a
// valid/ready stream, optionally clamps negatives to zero, and holds the result for the consumer.
module pe_accumulator #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Start,
    input  logic [CNT_W-1:0]  Len,
    input  logic              Relu_en,
    input  logic              In_valid,
    input  logic [DATA_W-1:0] In_data,
    output logic              In_ready,
    output logic              Out_valid,
    output logic [DATA_W-1:0] Out_data,
    input  logic              Out_ready,
    output logic              Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    len_q;
    logic                relu_q;
    logic                beat;
    logic                last_beat;
    logic [DATA_W-1:0]   sum;
    logic [DATA_W-1:0]   result;

    // Running sum wraps modulo 2^DATA_W; the sign bit of the final sum drives the ReLU clamp.
    always_comb begin
        beat      = In_valid && In_ready;
        last_beat = beat && (cnt_q == len_q - CNT_W'(1));
        sum       = acc_q + In_data;
        result    = (relu_q && sum[DATA_W-1]) ? '0 : sum;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = (Len != '0) ? ACC : DONE;
                end
            end
            ACC: begin
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (Out_valid && Out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decode only the state register, so no input reaches them combinationally.
    always_comb begin
        In_ready = (state_q == ACC);
        Busy     = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            relu_q    <= 1'b0;
            Out_valid <= 1'b0;
            Out_data  <= '0;
        end else begin
            Out_valid <= (state_d == DONE);
            unique case (state_q)
                IDLE: begin
                    if (Start && (Len != '0)) begin
                        len_q  <= Len;
                        relu_q <= Relu_en;
                        acc_q  <= '0;
                        cnt_q  <= '0;
                    end else if (Start) begin
                        Out_data <= '0;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc_q <= sum;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (last_beat) begin
                        Out_data <= result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_accumulator.sv
// Directed self-checking bench for pe_accumulator: each task drives one scenario
// and compares outputs sampled 1 time unit after the rising edge.
module tb_pe_accumulator;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic              Start;
    logic [CNT_W-1:0]  Len;
    logic              Relu_en;
    logic              In_valid;
    logic [DATA_W-1:0] In_data;
    logic              In_ready;
    logic              Out_valid;
    logic [DATA_W-1:0] Out_data;
    logic              Out_ready;
    logic              Busy;

    int checks = 0;
    int errors = 0;

    pe_accumulator #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .Len       (Len),
        .Relu_en   (Relu_en),
        .In_valid  (In_valid),
        .In_data   (In_data),
        .In_ready  (In_ready),
        .Out_valid (Out_valid),
        .Out_data  (Out_data),
        .Out_ready (Out_ready),
        .Busy      (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_job();
        Out_ready = 1'b1;
        step();
        Out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (In_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 0", In_ready); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", Busy); end
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", Out_valid); end
        checks++; if (Out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data got %h want 0", Out_data); end
        Start = 1'b1;
        Len   = 8'd3;
        step();
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_start_held got busy %b want 0", Busy); end
        Start = 1'b0;
        rst   = 1'b1;
        step();
    endtask

    task automatic test_basic_sum();
        Start = 1'b1; Len = 8'd4; Relu_en = 1'b0;
        step();
        Start = 1'b0;
        checks++; if (Busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got %b want 1", Busy); end
        for (int i = 0; i < 4; i++) begin
            In_valid = 1'b1;
            In_data  = 32'(i + 1);
            checks++; if (In_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_in_ready beat %0d got %b want 1", i, In_ready); end
            checks++; if (Out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid beat %0d got %b want 0", i, Out_valid); end
            step();
        end
        In_valid = 1'b0;
        checks++; if (Out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_out_valid got %b want 1", Out_valid); end
        checks++; if (Out_data !== 32'd10) begin errors++; $display("[TB] FAIL basic_out_data got %0d want 10", Out_data); end
        checks++; if (In_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_in_ready got %b want 0", In_ready); end
        finish_job();
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_drop got %b want 0", Out_valid); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle_busy got %b want 0", Busy); end
        checks++; if (Out_data !== 32'd10) begin errors++; $display("[TB] FAIL basic_data_retained got %0d want 10", Out_data); end
    endtask

    task automatic test_bubbles_backpressure();
        logic [DATA_W-1:0] terms [3];
        terms[0] = 32'd5; terms[1] = 32'd7; terms[2] = 32'd9;
        Start = 1'b1; Len = 8'd3; Relu_en = 1'b0;
        step();
        Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            In_valid = 1'b0;
            step();
            step();
            checks++; if (Out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bubble_valid term %0d got %b want 0", i, Out_valid); end
            In_valid = 1'b1;
            In_data  = terms[i];
            step();
        end
        In_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            Start = k[0];
            Len   = 8'd1;
            checks++; if (Out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid cycle %0d got %b want 1", k, Out_valid); end
            checks++; if (Out_data !== 32'd21) begin errors++; $display("[TB] FAIL stall_data cycle %0d got %0d want 21", k, Out_data); end
            checks++; if (In_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready cycle %0d got %b want 0", k, In_ready); end
            step();
        end
        Start = 1'b1;
        finish_job();
        Start = 1'b0;
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid_drop got %b want 0", Out_valid); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_idle got busy %b want 0", Busy); end
        step();
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_start_on_handshake got busy %b want 0", Busy); end
    endtask

    task automatic test_relu();
        logic [DATA_W-1:0] expect_data;
        for (int pass = 0; pass < 2; pass++) begin
            expect_data = (pass == 0) ? 32'h0000_0000 : 32'hFFFF_FFF3;
            Start   = 1'b1; Len = 8'd2;
            Relu_en = (pass == 0);
            step();
            Start   = 1'b0;
            Relu_en = (pass != 0);
            Len     = 8'd9;
            In_valid = 1'b1; In_data = 32'h0000_0003;
            step();
            In_data = 32'hFFFF_FFF0;
            step();
            In_valid = 1'b0;
            checks++; if (Out_valid !== 1'b1) begin errors++; $display("[TB] FAIL relu_valid pass %0d got %b want 1", pass, Out_valid); end
            checks++; if (Out_data !== expect_data) begin errors++; $display("[TB] FAIL relu_data pass %0d got %h want %h", pass, Out_data, expect_data); end
            finish_job();
        end
    endtask

    task automatic test_reset_mid_op();
        Start = 1'b1; Len = 8'd4; Relu_en = 1'b0;
        step();
        Start = 1'b0;
        In_valid = 1'b1; In_data = 32'd11;
        step();
        In_data = 32'd22;
        step();
        In_data = 32'd33;
        #2 rst = 1'b0;
        #1;
        checks++; if (In_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_in_ready got %b want 0", In_ready); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b want 0", Busy); end
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid got %b want 0", Out_valid); end
        checks++; if (Out_data !== 32'h0) begin errors++; $display("[TB] FAIL midrst_out_data got %h want 0", Out_data); end
        In_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_pulse got %b want 0", Out_valid); end
        Start = 1'b1; Len = 8'd1;
        step();
        Start = 1'b0;
        In_valid = 1'b1; In_data = 32'd6;
        step();
        In_valid = 1'b0;
        checks++; if (Out_valid !== 1'b1) begin errors++; $display("[TB] FAIL postrst_valid got %b want 1", Out_valid); end
        checks++; if (Out_data !== 32'd6) begin errors++; $display("[TB] FAIL postrst_data got %0d want 6", Out_data); end
        finish_job();
    endtask

    task automatic test_wrap_zero_len();
        Start = 1'b1; Len = 8'd2; Relu_en = 1'b0;
        step();
        Start = 1'b0;
        In_valid = 1'b1; In_data = 32'hFFFF_FFFF;
        step();
        In_data = 32'h0000_0002;
        step();
        In_valid = 1'b0;
        checks++; if (Out_data !== 32'h0000_0001) begin errors++; $display("[TB] FAIL wrap_data got %h want 00000001", Out_data); end
        finish_job();
        Start = 1'b1; Len = 8'd0;
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("[TB] FAIL zero_pre_valid got %b want 0", Out_valid); end
        step();
        Start = 1'b0;
        checks++; if (Out_valid !== 1'b1) begin errors++; $display("[TB] FAIL zero_valid got %b want 1", Out_valid); end
        checks++; if (Out_data !== 32'h0) begin errors++; $display("[TB] FAIL zero_data got %h want 0", Out_data); end
        checks++; if (In_ready !== 1'b0) begin errors++; $display("[TB] FAIL zero_in_ready got %b want 0", In_ready); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("[TB] FAIL zero_busy got %b want 1", Busy); end
        step();
        checks++; if (In_ready !== 1'b0) begin errors++; $display("[TB] FAIL zero_in_ready_hold got %b want 0", In_ready); end
        finish_job();
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("[TB] FAIL zero_valid_drop got %b want 0", Out_valid); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_idle got busy %b want 0", Busy); end
    endtask

    initial begin
        rst       = 1'b0;
        Start     = 1'b0;
        Len       = '0;
        Relu_en   = 1'b0;
        In_valid  = 1'b0;
        In_data   = '0;
        Out_ready = 1'b0;
        test_reset();
        test_basic_sum();
        test_bubbles_backpressure();
        test_relu();
        test_reset_mid_op();
        test_wrap_zero_len();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout got running want finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
